// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one multi-cycle alu among NumReq requesters
module alu_arbiter #(
  parameter int NumReq = 2,
  parameter int CountW = 16,
  parameter int NumW = 16,
  parameter int OpW = 2,
  localparam int ReqIdxW = $clog2(NumReq)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumReq-1:0][NumW-1:0]      req_left_i,
  input  logic [NumReq-1:0][NumW-1:0]      req_right_i,
  input  logic [NumReq-1:0][OpW-1:0]       req_op_i,
  input  logic [NumReq-1:0]                req_in_valid_i,
  output logic [NumReq-1:0]                req_in_ready_o,
  output logic [NumReq-1:0][NumW-1:0]      req_result_o,
  output logic [NumReq-1:0]                req_out_valid_o,
  input  logic [NumReq-1:0]                req_out_ready_i,
  output logic [NumW-1:0]                  alu_left_o,
  output logic [NumW-1:0]                  alu_right_o,
  output logic [OpW-1:0]                   alu_op_o,
  output logic                             alu_in_valid_o,
  input  logic                             alu_in_ready_i,
  input  logic [NumW-1:0]                  alu_result_i,
  input  logic                             alu_out_valid_i,
  output logic                             alu_out_ready_o,
  output logic                             busy_o,
  output logic [ReqIdxW-1:0]               grant_o,
  output logic [NumReq-1:0][CountW-1:0]    done_count_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic [ReqIdxW-1:0] grant_q, grant_d, last_q, cand;
  logic [NumReq-1:0][CountW-1:0] done_q;
  logic g_valid, done, issue, wait_st;

  assign g_valid = req_in_valid_i[grant_q];
  assign issue = state_q == ISSUE;
  assign wait_st = state_q == WAIT;
  assign done = wait_st && alu_out_valid_i && req_out_ready_i[grant_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q <= '0;
      last_q <= ReqIdxW'(NumReq - 1);
      done_q <= '0;
    end else begin
      grant_q <= grant_d;
      if (done) begin
        last_q <= grant_q;
        if (done_q[grant_q] != '1) done_q[grant_q] <= done_q[grant_q] + CountW'(1);
      end
    end
  end

  always_comb begin
    grant_d = grant_q;
    cand = '0;
    if (state_q == IDLE)
      for (int k = NumReq; k >= 1; k--) begin
        cand = ReqIdxW'((int'(last_q) + k) % NumReq);
        if (req_in_valid_i[cand]) grant_d = cand;
      end
  end

  always_comb begin
    state_d = state_q == IDLE  ? (|req_in_valid_i ? ISSUE : IDLE)
            : state_q == ISSUE ? (!g_valid ? IDLE : alu_in_ready_i ? WAIT : ISSUE)
            : wait_st && !done ? WAIT : IDLE;
  end

  always_comb begin
    busy_o = state_q != IDLE;
    alu_left_o = state_q != IDLE ? req_left_i[grant_q] : '0;
    alu_right_o = state_q != IDLE ? req_right_i[grant_q] : '0;
    alu_op_o = state_q != IDLE ? req_op_i[grant_q] : '0;
    alu_in_valid_o = issue && g_valid;
    req_in_ready_o = issue && alu_in_ready_i ? NumReq'(1) << grant_q : '0;
    req_out_valid_o = wait_st && alu_out_valid_i ? NumReq'(1) << grant_q : '0;
    alu_out_ready_o = wait_st && req_out_ready_i[grant_q];
    req_result_o = {NumReq{alu_result_i}};
    grant_o = grant_q;
    done_count_o = done_q;
  end
endmodule
